shift_frame_controller: RTL and testbench

SHIFT_FRAME_CONTROLLER -- requirements
Module: shift_frame_controller

---
 rtl/shift_frame_controller_if.sv | 34 +++
 rtl/shift_frame_controller.sv | 133 +++++++++++++
 tb/tb_shift_frame_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_frame_controller_if
//  Purpose  : Control/handshake bundle between a frame consumer and the
//             serial shift-frame controller.
//  Revision : 1.0  initial release
// ============================================================================
interface shift_frame_controller_if #(
    parameter int N = 11
);
    logic         start;
    logic         continuous;
    logic         abort;
    logic         serial_in;
    logic         frame_ready;
    logic         clear_overrun;
    logic         shift_clk_out;
    logic [N-1:0] frame_data;
    logic         frame_valid;
    logic         completed_shift;
    logic         busy;
    logic         overrun;

    modport master (
        output start, continuous, abort, serial_in, frame_ready, clear_overrun,
        input  shift_clk_out, frame_data, frame_valid, completed_shift, busy, overrun
    );

    modport slave (
        input  start, continuous, abort, serial_in, frame_ready, clear_overrun,
        output shift_clk_out, frame_data, frame_valid, completed_shift, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/shift_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module   : shift_frame_controller
//  Purpose  : Generates a divided shift clock, captures NUM_SHIFTS serial bits
//             MSB first into an N-bit frame and hands it off with valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module shift_frame_controller #(
    parameter int N          = 11,
    parameter int NUM_SHIFTS = 11,
    parameter int DIV        = 4
) (
    input  wire logic                 sync_clk,
    input  wire logic                 reset_n,
    shift_frame_controller_if.slave   sif
);

    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_BIT_W = (NUM_SHIFTS > 1) ? $clog2(NUM_SHIFTS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(DIV / 2);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(NUM_SHIFTS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [N-1:0]         r_shreg;
    logic [N-1:0]         r_frame_data;
    logic                 r_frame_valid;
    logic                 r_completed;
    logic                 r_shift_clk;
    logic                 r_overrun;

    logic                 w_sample;
    logic                 w_final;
    logic                 w_complete;
    logic                 w_overrun_set;
    logic [c_DIV_W-1:0]   w_div_next;
    logic [N-1:0]         w_shifted;

    assign w_sample      = (r_div_cnt == c_DIV_LAST);
    assign w_final       = w_sample && (r_bit_cnt == c_BIT_LAST);
    assign w_div_next    = w_sample ? '0 : r_div_cnt + 1'b1;
    // The cast drops the bit shifted out of the MSB.
    assign w_shifted     = N'({r_shreg, sif.serial_in});
    // Abort beats a coincident final sample, so it also suppresses completion.
    assign w_complete    = (r_state == S_SHIFT) && !sif.abort && w_final;
    assign w_overrun_set = w_complete && r_frame_valid && !sif.frame_ready;

    always_ff @(posedge sync_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_frame_data  <= '1;
            r_frame_valid <= 1'b0;
            r_completed   <= 1'b0;
            r_shift_clk   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_completed <= w_complete;

            if (w_complete) begin
                r_frame_data  <= w_shifted;
                r_frame_valid <= 1'b1;
            end else if (r_frame_valid && sif.frame_ready) begin
                r_frame_valid <= 1'b0;
            end

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (sif.clear_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_shift_clk <= 1'b0;
                    if (sif.start && !sif.abort) begin
                        r_state   <= S_SHIFT;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                    end
                end

                S_SHIFT: begin
                    if (sif.abort) begin
                        r_state     <= S_IDLE;
                        r_shift_clk <= 1'b0;
                        r_div_cnt   <= '0;
                        r_bit_cnt   <= '0;
                        r_shreg     <= '0;
                    end else begin
                        r_div_cnt   <= w_div_next;
                        // Clock is derived from the next count so it stays aligned with div_cnt.
                        r_shift_clk <= (w_div_next >= c_DIV_HALF);
                        if (w_sample) begin
                            if (w_final) begin
                                r_bit_cnt <= '0;
                                r_shreg   <= '0;
                                if (!sif.continuous) begin
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_shreg   <= w_shifted;
                            end
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sif.shift_clk_out   = r_shift_clk;
    assign sif.frame_data      = r_frame_data;
    assign sif.frame_valid     = r_frame_valid;
    assign sif.completed_shift = r_completed;
    assign sif.busy            = (r_state == S_SHIFT);
    assign sif.overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_shift_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_frame_controller
//  Purpose  : Directed bench for shift_frame_controller with a cycle-level
//             frame model (11-bit build) and a NUM_SHIFTS=8 build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_frame_controller;

    localparam int N   = 11;
    localparam int NS  = 11;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    shift_frame_controller_if #(.N(N)) sif1 ();
    shift_frame_controller_if #(.N(N)) sif2 ();

    shift_frame_controller #(.N(N), .NUM_SHIFTS(NS), .DIV(DIV)) u_dut (
        .sync_clk (clk),
        .reset_n  (reset_n),
        .sif      (sif1)
    );

    shift_frame_controller #(.N(N), .NUM_SHIFTS(8), .DIV(DIV)) u_dut8 (
        .sync_clk (clk),
        .reset_n  (reset_n),
        .sif      (sif2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: counts edges since the frame began; every DIV-th edge takes a bit.
    logic [N-1:0] m_data   = '1;
    logic         m_valid  = 1'b0;
    logic         m_done   = 1'b0;
    logic         m_active = 1'b0;
    logic         m_ovr    = 1'b0;
    logic         m_cmp    = 1'b0;
    int           m_t      = 0;
    int           m_val    = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data = '1; m_valid = 0; m_done = 0; m_active = 0; m_ovr = 0;
            m_t = 0; m_val = 0;
        end else begin
            m_cmp = 0;
            if (m_active) begin
                if (sif1.abort) begin
                    m_active = 0;
                end else begin
                    m_t++;
                    if (m_t % DIV == 0) begin
                        m_val = m_val * 2 + int'(sif1.serial_in);
                        if (m_t == NS * DIV) m_cmp = 1;
                    end
                end
            end else if (sif1.start && !sif1.abort) begin
                m_active = 1; m_t = 0; m_val = 0;
            end
            m_done = m_cmp;
            if (m_cmp) begin
                if (m_valid && !sif1.frame_ready) m_ovr = 1;
                else if (sif1.clear_overrun) m_ovr = 0;
                m_data  = N'(m_val);
                m_valid = 1;
                if (sif1.continuous) begin m_t = 0; m_val = 0; end
                else m_active = 0;
            end else begin
                if (m_valid && sif1.frame_ready) m_valid = 0;
                if (sif1.clear_overrun) m_ovr = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cycle{data,valid,done,busy,sclk,ovr}",
              {16'h0, sif1.frame_data, sif1.frame_valid, sif1.completed_shift,
               sif1.busy, sif1.shift_clk_out, sif1.overrun},
              {16'h0, m_data, m_valid, m_done, m_active,
               (m_active && ((m_t % DIV) >= DIV / 2)), m_ovr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int nbits, input bit ready_last);
        for (int k = nbits - 1; k >= 0; k--) begin
            sif1.serial_in = bits[k];
            sif2.serial_in = bits[k];
            if (k == 0 && ready_last) begin
                repeat (DIV - 1) tick();
                sif1.frame_ready = 1'b1;
                tick();
                sif1.frame_ready = 1'b0;
            end else begin
                repeat (DIV) tick();
            end
        end
    endtask

    task automatic start_frame();
        sif1.start = 1'b1;
        tick();
        sif1.start = 1'b0;
    endtask

    task automatic ack();
        sif1.frame_ready = 1'b1;
        tick();
        sif1.frame_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        sif1.start = 0; sif1.continuous = 0; sif1.abort = 0; sif1.serial_in = 0;
        sif1.frame_ready = 0; sif1.clear_overrun = 0;
        sif2.start = 0; sif2.continuous = 0; sif2.abort = 0; sif2.serial_in = 0;
        sif2.frame_ready = 0; sif2.clear_overrun = 0;
        repeat (3) tick();
        check("reset frame_data", 32'(sif1.frame_data), 32'h7FF);
        check("reset flags{valid,done,busy,sclk,ovr}",
              {27'h0, sif1.frame_valid, sif1.completed_shift, sif1.busy, sif1.shift_clk_out, sif1.overrun}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Single frame 0x5A5 with latency check.
        start_frame();
        send_bits(32'h5A5 >> 1, 10, 1'b0);
        sif1.serial_in = 1'b1;
        repeat (DIV - 1) tick();
        check("valid before E0+44", 32'(sif1.frame_valid), 32'h0);
        tick();
        check("frame 0x5A5 data", 32'(sif1.frame_data), 32'h5A5);
        check("frame 0x5A5 {valid,done,busy}",
              {29'h0, sif1.frame_valid, sif1.completed_shift, sif1.busy}, 32'h6);
        tick();
        check("completed pulse width", 32'(sif1.completed_shift), 32'h0);
        ack();
        check("valid cleared by ready", 32'(sif1.frame_valid), 32'h0);

        // Continuous, no consumer: second frame overruns.
        sif1.continuous = 1'b1;
        start_frame();
        send_bits(32'h123, 11, 1'b0);
        check("cont frame1 data", 32'(sif1.frame_data), 32'h123);
        sif1.continuous = 1'b0;
        send_bits(32'h7FF, 11, 1'b0);
        check("overrun {data,valid,ovr}",
              {19'h0, sif1.frame_data, sif1.frame_valid, sif1.overrun}, {19'h0, 11'h7FF, 2'b11});
        sif1.clear_overrun = 1'b1;
        tick();
        sif1.clear_overrun = 1'b0;
        check("clear_overrun {valid,ovr}", {30'h0, sif1.frame_valid, sif1.overrun}, 32'h2);
        ack();

        // Continuous, ready lands exactly on the second completion edge.
        sif1.continuous = 1'b1;
        start_frame();
        send_bits(32'h0F0, 11, 1'b0);
        sif1.continuous = 1'b0;
        send_bits(32'h30C, 11, 1'b1);
        check("ready@complete {data,valid,ovr}",
              {19'h0, sif1.frame_data, sif1.frame_valid, sif1.overrun}, {19'h0, 11'h30C, 2'b10});
        ack();

        // Abort after six bits while the shift clock is high.
        start_frame();
        send_bits(32'h2AB >> 5, 6, 1'b0);
        tick();
        tick();
        check("sclk high before abort", 32'(sif1.shift_clk_out), 32'h1);
        sif1.abort = 1'b1;
        tick();
        sif1.abort = 1'b0;
        check("abort {busy,sclk,done}", {29'h0, sif1.busy, sif1.shift_clk_out, sif1.completed_shift}, 32'h0);
        check("abort keeps data", 32'(sif1.frame_data), 32'h30C);
        sif1.start = 1'b1; sif1.abort = 1'b1;
        tick();
        sif1.start = 1'b0; sif1.abort = 1'b0;
        check("abort beats start", 32'(sif1.busy), 32'h0);
        start_frame();
        send_bits(32'h2AB, 11, 1'b0);
        check("frame after abort", 32'(sif1.frame_data), 32'h2AB);

        // Asynchronous reset between edges, mid-frame.
        start_frame();
        send_bits(32'h5, 3, 1'b0);
        #2;
        reset_n = 1'b0;
        sif1.start = 1'b1;
        #1;
        check("async reset data", 32'(sif1.frame_data), 32'h7FF);
        check("async reset {valid,done,busy,sclk,ovr}",
              {27'h0, sif1.frame_valid, sif1.completed_shift, sif1.busy, sif1.shift_clk_out, sif1.overrun}, 32'h0);
        tick();
        tick();
        check("start ignored in reset", 32'(sif1.busy), 32'h0);
        sif1.start = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        check("idle after release", 32'(sif1.busy), 32'h0);

        // NUM_SHIFTS=8 build: byte 0xC3.
        sif2.start = 1'b1;
        tick();
        sif2.start = 1'b0;
        send_bits(32'hC3 >> 1, 7, 1'b0);
        sif1.serial_in = 1'b1;
        sif2.serial_in = 1'b1;
        repeat (DIV - 1) tick();
        check("ns8 valid before E0+32", 32'(sif2.frame_valid), 32'h0);
        tick();
        check("ns8 data", 32'(sif2.frame_data), 32'h0C3);
        check("ns8 {valid,done,busy}", {29'h0, sif2.frame_valid, sif2.completed_shift, sif2.busy}, 32'h6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
